// File: rtl/rv32i_pkg.sv
// Shared RV32I register-file constants.
package rv32i_pkg;

  // Default register width and register count.
  localparam int unsigned XLEN_DEF  = 32;
  localparam int unsigned NREGS_DEF = 32;

  // Index of the hardwired-zero register.
  localparam int unsigned REG_ZERO = 0;

endpackage

// File: rtl/regfile_read_port.sv
// One register-file read port: zero-force, write bypass and scoreboard hit.
module regfile_read_port
  import rv32i_pkg::*;
#(
  parameter int unsigned XLEN   = XLEN_DEF,
  parameter int unsigned NREGS  = NREGS_DEF,
  parameter int unsigned AW     = $clog2(NREGS),
  parameter int unsigned BYPASS = 1
) (
  input  logic [AW-1:0]   raddr,
  input  logic            rs_used,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic [XLEN-1:0] regs [NREGS],
  input  logic [NREGS-1:0] busy,
  output logic [XLEN-1:0] rdata,
  output logic            hit
);

  logic addr_nz;
  logic fwd;

  assign addr_nz = (raddr != AW'(REG_ZERO));
  // Since raddr is nonzero whenever fwd matters, waddr==raddr implies waddr!=0.
  assign fwd     = (BYPASS != 0) && we && (waddr == raddr) && addr_nz;

  // Read mux: x0 reads zero, same-cycle writeback wins over the stored value.
  always_comb begin
    rdata = '0;
    if (addr_nz) begin
      rdata = fwd ? wdata : regs[raddr];
    end
  end

  assign hit = rs_used & busy[raddr] & addr_nz & ~fwd;

endmodule

// File: rtl/regfile_scoreboard.sv
// Register file with per-register pending-write scoreboard and issue stall.
module regfile_scoreboard
  import rv32i_pkg::*;
#(
  parameter int unsigned XLEN   = XLEN_DEF,
  parameter int unsigned NREGS  = NREGS_DEF,
  parameter int unsigned NRD    = 2,
  parameter int unsigned BYPASS = 1,
  localparam int unsigned AW    = $clog2(NREGS)
) (
  input  logic                Clk,
  input  logic                Clear,
  input  logic                we,
  input  logic [AW-1:0]       waddr,
  input  logic [XLEN-1:0]     wdata,
  input  logic [NRD*AW-1:0]   raddr,
  input  logic [NRD-1:0]      rs_used,
  output logic [NRD*XLEN-1:0] rdata,
  input  logic                issue_valid,
  input  logic [AW-1:0]       issue_rd,
  output logic                stall,
  output logic [NREGS-1:0]    busy_vec
);

  logic [XLEN-1:0]  regs [NREGS];
  logic [NREGS-1:0] busy;
  logic [NRD-1:0]   hit;
  logic             accept;
  logic             wr_en;

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    regfile_read_port #(
      .XLEN  (XLEN),
      .NREGS (NREGS),
      .AW    (AW),
      .BYPASS(BYPASS)
    ) u_read_port (
      .raddr  (raddr[i*AW +: AW]),
      .rs_used(rs_used[i]),
      .we     (we),
      .waddr  (waddr),
      .wdata  (wdata),
      .regs   (regs),
      .busy   (busy),
      .rdata  (rdata[i*XLEN +: XLEN]),
      .hit    (hit[i])
    );
  end

  assign stall    = issue_valid & (|hit);
  assign accept   = issue_valid & ~stall;
  assign wr_en    = we & (waddr != AW'(REG_ZERO));
  assign busy_vec = busy;

  // Storage and scoreboard; an issue-set is applied after the writeback-clear so set wins.
  always_ff @(posedge Clk or negedge Clear) begin
    if (!Clear) begin
      for (int r = 0; r < int'(NREGS); r++) begin
        regs[r] <= '0;
      end
      busy <= '0;
    end else begin
      if (wr_en) begin
        regs[waddr] <= wdata;
        busy[waddr] <= 1'b0;
      end
      if (accept && (issue_rd != AW'(REG_ZERO))) begin
        busy[issue_rd] <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Self-checking bench: directed table, reset/bypass sequences, randomized model compare.
module tb_regfile_scoreboard;

  logic        Clk = 1'b0;
  logic        Clear = 1'b0;
  logic        we = 1'b0;
  logic [4:0]  waddr = '0;
  logic [31:0] wdata = '0;
  logic [9:0]  raddr = '0;
  logic [1:0]  rs_used = '0;
  logic        issue_valid = 1'b0;
  logic [4:0]  issue_rd = '0;
  logic [63:0] rdata, rdata_nb;
  logic        stall, stall_nb;
  logic [31:0] busy_vec, busy_vec_nb;

  int checks = 0;
  int errors = 0;

  always #5 Clk = ~Clk;

  regfile_scoreboard #(.XLEN(32), .NREGS(32), .NRD(2), .BYPASS(1)) dut (
    .Clk(Clk), .Clear(Clear), .we(we), .waddr(waddr), .wdata(wdata), .raddr(raddr),
    .rs_used(rs_used), .rdata(rdata), .issue_valid(issue_valid), .issue_rd(issue_rd),
    .stall(stall), .busy_vec(busy_vec)
  );

  regfile_scoreboard #(.XLEN(32), .NREGS(32), .NRD(2), .BYPASS(0)) dut_nb (
    .Clk(Clk), .Clear(Clear), .we(we), .waddr(waddr), .wdata(wdata), .raddr(raddr),
    .rs_used(rs_used), .rdata(rdata_nb), .issue_valid(issue_valid), .issue_rd(issue_rd),
    .stall(stall_nb), .busy_vec(busy_vec_nb)
  );

  // Reference model: architectural register values and pending-write sets.
  logic [31:0] mregs [32];
  bit          mb  [32];
  bit          mbn [32];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic w, input logic [4:0] wa, input logic [31:0] wd,
                       input logic [4:0] r0, input logic [4:0] r1, input logic [1:0] ru,
                       input logic iv, input logic [4:0] rd);
    we = w; waddr = wa; wdata = wd; raddr = {r1, r0}; rs_used = ru;
    issue_valid = iv; issue_rd = rd;
  endtask

  task automatic idle_in();
    drive(1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 2'b00, 1'b0, 5'd0);
  endtask

  task automatic model_clear();
    for (int r = 0; r < 32; r++) begin
      mregs[r] = '0; mb[r] = 0; mbn[r] = 0;
    end
  endtask

  function automatic logic [31:0] m_rd(input bit byp, input logic [4:0] ra);
    if (ra == 0) return 32'd0;
    if (byp && we && waddr == ra) return wdata;
    return mregs[ra];
  endfunction

  function automatic logic m_stall(input bit byp);
    logic s = 1'b0;
    for (int i = 0; i < 2; i++) begin
      logic [4:0] ra = raddr[i*5 +: 5];
      bit pend = byp ? mb[ra] : mbn[ra];
      if (rs_used[i] && ra != 0 && pend && !(byp && we && waddr == ra)) s = 1'b1;
    end
    return issue_valid & s;
  endfunction

  function automatic logic [31:0] m_busy(input bit byp);
    logic [31:0] v = '0;
    for (int r = 0; r < 32; r++) v[r] = byp ? mb[r] : mbn[r];
    return v;
  endfunction

  // Apply one clock edge's worth of architectural effects to the model.
  task automatic model_edge();
    logic s1 = m_stall(1'b1);
    logic s0 = m_stall(1'b0);
    if (we && waddr != 0) begin
      mregs[waddr] = wdata; mb[waddr] = 0; mbn[waddr] = 0;
    end
    if (issue_valid && !s1 && issue_rd != 0) mb[issue_rd] = 1;
    if (issue_valid && !s0 && issue_rd != 0) mbn[issue_rd] = 1;
  endtask

  task automatic check_model();
    chk("rd0", {32'd0, rdata[31:0]}, {32'd0, m_rd(1'b1, raddr[4:0])});
    chk("rd1", {32'd0, rdata[63:32]}, {32'd0, m_rd(1'b1, raddr[9:5])});
    chk("stall", {63'd0, stall}, {63'd0, m_stall(1'b1)});
    chk("busy", {32'd0, busy_vec}, {32'd0, m_busy(1'b1)});
    chk("nb_rd0", {32'd0, rdata_nb[31:0]}, {32'd0, m_rd(1'b0, raddr[4:0])});
    chk("nb_rd1", {32'd0, rdata_nb[63:32]}, {32'd0, m_rd(1'b0, raddr[9:5])});
    chk("nb_stall", {63'd0, stall_nb}, {63'd0, m_stall(1'b0)});
    chk("nb_busy", {32'd0, busy_vec_nb}, {32'd0, m_busy(1'b0)});
  endtask

  task automatic hard_reset();
    @(negedge Clk);
    idle_in();
    Clear = 1'b0;
    @(negedge Clk);
    Clear = 1'b1;
    model_clear();
  endtask

  typedef struct {
    logic        w;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  r0, r1;
    logic [1:0]  ru;
    logic        iv;
    logic [4:0]  rd;
    logic [31:0] e0, e1;
    logic        es;
    logic [31:0] eb;
  } vec_t;

  vec_t tbl [15];

  initial begin
    // Expected values are pre-edge observations for the bypassing instance.
    tbl[0]  = '{1'b0, 5'd0, 32'h0,        5'd0, 5'd1, 2'b00, 1'b0, 5'd0, 32'h0,        32'h0,        1'b0, 32'h0};
    tbl[1]  = '{1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd0, 2'b00, 1'b0, 5'd0, 32'hDEADBEEF, 32'h0,        1'b0, 32'h0};
    tbl[2]  = '{1'b0, 5'd0, 32'h0,        5'd5, 5'd5, 2'b00, 1'b0, 5'd0, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 32'h0};
    tbl[3]  = '{1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd5, 2'b00, 1'b0, 5'd0, 32'h0,        32'hDEADBEEF, 1'b0, 32'h0};
    tbl[4]  = '{1'b0, 5'd0, 32'h0,        5'd0, 5'd0, 2'b00, 1'b1, 5'd0, 32'h0,        32'h0,        1'b0, 32'h0};
    tbl[5]  = '{1'b0, 5'd0, 32'h0,        5'd0, 5'd0, 2'b00, 1'b1, 5'd7, 32'h0,        32'h0,        1'b0, 32'h0};
    tbl[6]  = '{1'b0, 5'd0, 32'h0,        5'd7, 5'd0, 2'b01, 1'b1, 5'd3, 32'h0,        32'h0,        1'b1, 32'h80};
    tbl[7]  = '{1'b1, 5'd7, 32'h12345678, 5'd7, 5'd0, 2'b01, 1'b1, 5'd3, 32'h12345678, 32'h0,        1'b0, 32'h80};
    tbl[8]  = '{1'b0, 5'd0, 32'h0,        5'd7, 5'd3, 2'b00, 1'b0, 5'd0, 32'h12345678, 32'h0,        1'b0, 32'h8};
    tbl[9]  = '{1'b1, 5'd9, 32'hAA,       5'd0, 5'd0, 2'b00, 1'b1, 5'd9, 32'h0,        32'h0,        1'b0, 32'h8};
    tbl[10] = '{1'b0, 5'd0, 32'h0,        5'd9, 5'd0, 2'b00, 1'b0, 5'd0, 32'hAA,       32'h0,        1'b0, 32'h208};
    tbl[11] = '{1'b0, 5'd0, 32'h0,        5'd0, 5'd0, 2'b00, 1'b1, 5'd9, 32'h0,        32'h0,        1'b0, 32'h208};
    tbl[12] = '{1'b0, 5'd0, 32'h0,        5'd0, 5'd3, 2'b10, 1'b0, 5'd0, 32'h0,        32'h0,        1'b0, 32'h208};
    tbl[13] = '{1'b0, 5'd0, 32'h0,        5'd0, 5'd3, 2'b10, 1'b1, 5'd0, 32'h0,        32'h0,        1'b1, 32'h208};
    tbl[14] = '{1'b0, 5'd0, 32'h0,        5'd3, 5'd0, 2'b00, 1'b1, 5'd0, 32'h0,        32'h0,        1'b0, 32'h208};

    model_clear();
    #2 Clear = 1'b0;
    #20 Clear = 1'b1;

    // Fresh reset: every index reads zero on both ports.
    for (int a = 0; a < 32; a++) begin
      @(negedge Clk);
      drive(1'b0, 5'd0, 32'd0, 5'(a), 5'(31 - a), 2'b11, 1'b1, 5'd0);
      #2;
      chk("reset_rd0", {32'd0, rdata[31:0]}, 64'd0);
      chk("reset_rd1", {32'd0, rdata[63:32]}, 64'd0);
      chk("reset_stall", {63'd0, stall}, 64'd0);
      chk("reset_busy", {32'd0, busy_vec}, 64'd0);
    end
    hard_reset();

    // Directed table.
    for (int k = 0; k < 15; k++) begin
      @(negedge Clk);
      drive(tbl[k].w, tbl[k].wa, tbl[k].wd, tbl[k].r0, tbl[k].r1, tbl[k].ru, tbl[k].iv,
            tbl[k].rd);
      #2;
      chk($sformatf("tbl%0d_rd0", k), {32'd0, rdata[31:0]}, {32'd0, tbl[k].e0});
      chk($sformatf("tbl%0d_rd1", k), {32'd0, rdata[63:32]}, {32'd0, tbl[k].e1});
      chk($sformatf("tbl%0d_stall", k), {63'd0, stall}, {63'd0, tbl[k].es});
      chk($sformatf("tbl%0d_busy", k), {32'd0, busy_vec}, {32'd0, tbl[k].eb});
    end

    // Asynchronous reset mid-cycle with bits 3 and 9 pending.
    @(negedge Clk);
    drive(1'b0, 5'd0, 32'd0, 5'd9, 5'd3, 2'b11, 1'b1, 5'd0);
    #1;
    chk("pre_clear_busy", {32'd0, busy_vec}, 64'h208);
    Clear = 1'b0;
    #1;
    chk("async_busy", {32'd0, busy_vec}, 64'd0);
    chk("async_rd0", {32'd0, rdata[31:0]}, 64'd0);
    chk("async_stall", {63'd0, stall}, 64'd0);
    drive(1'b1, 5'd4, 32'h55, 5'd4, 5'd9, 2'b00, 1'b1, 5'd6);
    #1;
    chk("clear_bypass", {32'd0, rdata[31:0]}, 64'h55);
    @(negedge Clk);
    drive(1'b0, 5'd0, 32'd0, 5'd4, 5'd9, 2'b00, 1'b0, 5'd0);
    #1;
    chk("clear_wr_ignored", {32'd0, rdata[31:0]}, 64'd0);
    chk("clear_set_ignored", {32'd0, busy_vec}, 64'd0);
    Clear = 1'b1;
    model_clear();

    // No-bypass instance: same-cycle writeback is visible only next cycle and still stalls.
    @(negedge Clk);
    drive(1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd0, 2'b00, 1'b1, 5'd7);
    #2;
    chk("nb_same_cycle", {32'd0, rdata_nb[31:0]}, 64'd0);
    chk("byp_same_cycle", {32'd0, rdata[31:0]}, 64'hDEADBEEF);
    @(posedge Clk); model_edge();
    @(negedge Clk);
    drive(1'b1, 5'd7, 32'h77, 5'd7, 5'd5, 2'b01, 1'b1, 5'd0);
    #2;
    chk("nb_next_cycle", {32'd0, rdata_nb[63:32]}, 64'hDEADBEEF);
    chk("nb_wb_stall", {63'd0, stall_nb}, 64'd1);
    chk("byp_wb_nostall", {63'd0, stall}, 64'd0);
    check_model();
    @(posedge Clk); model_edge();

    // Randomized traffic against the model; small index range makes hazards frequent.
    hard_reset();
    for (int n = 0; n < 400; n++) begin
      @(negedge Clk);
      drive(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)));
      #2;
      check_model();
      @(posedge Clk);
      model_edge();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_scoreboard.md
REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

Interface
REQ-001 Parameter XLEN, default 32, data width of each register.
REQ-002 Parameter NREGS, default 32, register count (power of 2, >=2); AW = log2(NREGS).
REQ-003 Parameter NRD, default 2, number of read ports.
REQ-004 Parameter BYPASS, default 1, enables write-to-read forwarding within the same cycle when 1.
REQ-005 Clk  input  1  single clock, all state updates on rising edge.
REQ-006 Clear  input  1  reset, asynchronous, active-low.
REQ-007 we  input  1  writeback enable.
REQ-008 waddr  input  AW  writeback register index.
REQ-009 wdata  input  XLEN  writeback data.
REQ-010 raddr  input  NRD*AW  read indices, port i in slice i.
REQ-011 rs_used  input  NRD  port i holds a real source operand this cycle.
REQ-012 rdata  output  NRD*XLEN  read data, port i in slice i.
REQ-013 issue_valid  input  1  an instruction requests issue this cycle.
REQ-014 issue_rd  input  AW  destination of the issuing instruction (0 = no destination).
REQ-015 stall  output  1  issue refused this cycle due to a pending source.
REQ-016 busy_vec  output  NREGS  current pending-write bit per register.

Function
REQ-017 rdata[i] SHALL be combinational: 0 when raddr[i]==0; wdata when BYPASS==1, we==1, waddr==raddr[i], waddr!=0; otherwise the stored register.
REQ-018 On the rising edge with we==1 and waddr!=0, register[waddr] SHALL take wdata; writes to index 0 SHALL be discarded.
REQ-019 hit[i] = rs_used[i] & busy[raddr[i]] & (raddr[i]!=0) & ~(BYPASS & we & waddr==raddr[i]).
REQ-020 stall SHALL equal issue_valid & OR over i of hit[i], combinationally, with no dependence on issue_rd.
REQ-021 Issue SHALL be accepted when issue_valid==1 and stall==0; on acceptance with issue_rd!=0, busy[issue_rd] SHALL be set on the next edge.
REQ-022 On the rising edge with we==1 and waddr!=0, busy[waddr] SHALL clear.
REQ-023 Simultaneous accept-set and writeback-clear on the same index: set SHALL win (busy==1 afterwards).
REQ-024 Accepted issue to an already-busy rd (WAW) SHALL leave busy set; no stall is raised for rd.
REQ-025 Writeback to a non-busy register SHALL update data and leave busy==0.
REQ-026 busy[0] SHALL be constant 0.
REQ-027 With BYPASS==0, a source whose writeback arrives in the same cycle SHALL still stall; data becomes visible the following cycle.
REQ-028 All outputs SHALL settle within the cycle; write-to-stored-read latency is one edge, bypass latency zero.

Reset
REQ-029 Clear low SHALL immediately, without a clock edge, zero every register and every busy bit.
REQ-030 While Clear is low, writes and issue-sets SHALL be ignored; rdata SHALL read 0 except a bypassed wdata per REQ-017, and stall SHALL be 0.
REQ-031 Reset asserted mid-operation SHALL discard all pending busy bits; first edge after Clear rises behaves as a fresh start.

Structure
REQ-032 XLEN, NREGS defaults and the constant REG_ZERO=0 SHALL live in the shared package rv32i_pkg.
REQ-033 One sub-module regfile_read_port SHALL implement the per-port mux, zero-force, bypass and hit[i]; instantiated NRD times by generate.
REQ-034 Storage and busy bits SHALL be one always block with asynchronous active-low reset; no latches.

Verification
REQ-035 Reset then read all indices on both ports -> rdata==0, busy_vec==0, stall==0.
REQ-036 we=1 waddr=5 wdata=32'hDEADBEEF, raddr0=5 same cycle -> rdata0==32'hDEADBEEF (BYPASS=1); with BYPASS=0 -> 0 that cycle, 32'hDEADBEEF next.
REQ-037 Write waddr=0 wdata=32'hFFFFFFFF, read raddr=0 -> rdata==0; issue_rd=0 -> busy_vec unchanged.
REQ-038 Accept issue rd=7; next cycle issue_valid=1 rs_used0=1 raddr0=7 -> stall==1 and busy unchanged; then we=1 waddr=7 wdata=32'h12345678 -> stall==0, rdata0==32'h12345678, busy[7] clears.
REQ-039 Same edge: accepted issue rd=9 and we=1 waddr=9 -> busy[9]==1 afterwards.
REQ-040 Busy bits 3,9 set, drop Clear between edges -> busy_vec==0 and all registers 0 before next edge.
